// File: rtl/icap_defs.sv
// Spartan-6 ICAP command words, configuration register addresses and the
// reader FSM state type, shared by the ICAP reader and multiboot writer.
package icap_defs;

  localparam logic [15:0] ICAP_DUMMY      = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC1      = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC2      = 16'h5566;
  localparam logic [15:0] ICAP_NOOP       = 16'h2000;
  localparam logic [15:0] ICAP_WR_CMD     = 16'h30A1;
  localparam logic [15:0] ICAP_CMD_DESYNC = 16'h000D;
  localparam logic [15:0] ICAP_CMD_REBOOT = 16'h000E;
  localparam logic [15:0] ICAP_T1_RD      = 16'h2800;

  localparam logic [5:0] REG_STAT     = 6'h08;
  localparam logic [5:0] REG_GENERAL1 = 6'h13;
  localparam logic [5:0] REG_GENERAL2 = 6'h14;
  localparam logic [5:0] REG_GENERAL3 = 6'h15;
  localparam logic [5:0] REG_GENERAL4 = 6'h16;
  localparam logic [5:0] REG_GENERAL5 = 6'h17;
  localparam logic [5:0] REG_BOOTSTS  = 6'h20;

  typedef enum logic [4:0] {
    S_IDLE, S_DUMMY, S_SYNC_H, S_SYNC_L, S_NOOP_A, S_HDR, S_NOOP_B0, S_NOOP_B1,
    S_TURN_R0, S_TURN_R1, S_RD_ACT, S_TURN_W0, S_TURN_W1, S_DSYNC_C, S_DSYNC_V,
    S_NOOP_C0, S_NOOP_C1, S_DONE
  } rd_state_t;

  // Type-1 packet header: read one word from register addr
  function automatic logic [15:0] t1_rd_hdr(input logic [5:0] addr);
    return ICAP_T1_RD | {5'b00000, addr, 5'b00001};
  endfunction

endpackage

// File: rtl/icap_byteswap.sv
// Per-byte bit reversal between fabric word order and ICAP pin order.
module icap_byteswap (
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      q[i]     = d[7 - i];
      q[8 + i] = d[15 - i];
    end
  end

endmodule

// File: rtl/icap_reg_reader.sv
// Reads one 16-bit Spartan-6 configuration register through ICAP:
// sync, type-1 read header, polled read, desync, all on registered raw pins.
module icap_reg_reader
  import icap_defs::*;
#(
  parameter int unsigned RD_WAIT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RD_REQ,
  input  logic [5:0]  RD_ADDR,
  output logic        RD_BUSY,
  output logic        RD_VALID,
  output logic [15:0] RD_DATA,
  output logic        RD_ERR,
  output logic        ICAP_CE,
  output logic        ICAP_WRITE,
  output logic [15:0] ICAP_I,
  input  logic [15:0] ICAP_O,
  input  logic        ICAP_BUSY
);

  localparam int unsigned CNT_MAX = (RD_WAIT > TIMEOUT) ? RD_WAIT : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  rd_state_t        state, next_state;
  logic             raw_ce, raw_wr;
  logic [15:0]      raw_din, swapped_din, o_unswap;
  logic [5:0]       addr_q;
  logic [CNT_W-1:0] cnt;
  logic             polling;
  logic             act_done, act_err;

  icap_byteswap u_swap_i (.d(raw_din), .q(swapped_din));
  icap_byteswap u_swap_o (.d(ICAP_O),  .q(o_unswap));

  always_comb begin
    next_state = state;
    raw_ce     = 1'b1;
    raw_wr     = 1'b1;
    raw_din    = ICAP_DUMMY;
    act_done   = 1'b0;
    act_err    = 1'b0;
    case (state)
      S_IDLE:    if (RD_REQ) next_state = S_DUMMY;
      S_DUMMY:   begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_DUMMY; next_state = S_SYNC_H; end
      S_SYNC_H:  begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_SYNC1; next_state = S_SYNC_L; end
      S_SYNC_L:  begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_SYNC2; next_state = S_NOOP_A; end
      S_NOOP_A:  begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_NOOP;  next_state = S_HDR; end
      S_HDR:     begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = t1_rd_hdr(addr_q); next_state = S_NOOP_B0; end
      S_NOOP_B0: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_NOOP;  next_state = S_NOOP_B1; end
      S_NOOP_B1: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_NOOP;  next_state = S_TURN_R0; end
      S_TURN_R0: begin raw_wr = 1'b0; next_state = S_TURN_R1; end
      S_TURN_R1: next_state = S_RD_ACT;
      S_RD_ACT: begin
        raw_ce = 1'b0;
        // The RD_WAIT-th cycle is the first BUSY poll; timeout counts only later polls
        if (!polling) begin
          if (cnt == WAIT_LAST && !ICAP_BUSY) act_done = 1'b1;
        end else if (!ICAP_BUSY) begin
          act_done = 1'b1;
        end else if (cnt == TO_LAST) begin
          act_done = 1'b1;
          act_err  = 1'b1;
        end
        if (act_done) next_state = S_TURN_W0;
      end
      S_TURN_W0: next_state = S_TURN_W1;
      S_TURN_W1: begin raw_wr = 1'b0; next_state = S_DSYNC_C; end
      S_DSYNC_C: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_WR_CMD;     next_state = S_DSYNC_V; end
      S_DSYNC_V: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_CMD_DESYNC; next_state = S_NOOP_C0; end
      S_NOOP_C0: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_NOOP;       next_state = S_NOOP_C1; end
      S_NOOP_C1: begin raw_ce = 1'b0; raw_wr = 1'b0; raw_din = ICAP_NOOP;       next_state = S_DONE; end
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      ICAP_CE    <= 1'b1;
      ICAP_WRITE <= 1'b1;
      ICAP_I     <= 16'hFFFF;
      RD_BUSY    <= 1'b0;
      RD_VALID   <= 1'b0;
      RD_DATA    <= '0;
      RD_ERR     <= 1'b0;
      addr_q     <= '0;
      cnt        <= '0;
      polling    <= 1'b0;
    end else begin
      state      <= next_state;
      ICAP_CE    <= raw_ce;
      ICAP_WRITE <= raw_wr;
      ICAP_I     <= swapped_din;
      RD_BUSY    <= (next_state != S_IDLE);
      RD_VALID   <= (next_state == S_DONE);
      if (state == S_IDLE && RD_REQ) addr_q <= RD_ADDR;
      if (state != S_RD_ACT) begin
        cnt     <= '0;
        polling <= 1'b0;
      end else if (!polling && cnt == WAIT_LAST) begin
        cnt     <= '0;
        polling <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (act_done) begin
        RD_DATA <= act_err ? 16'h0000 : o_unswap;
        RD_ERR  <= act_err;
      end
    end
  end

endmodule

// File: tb/tb_icap_reg_reader.sv
// Directed bench for icap_reg_reader with a behavioural ICAP model that logs
// written words and answers reads after a programmable BUSY stretch.
module tb_icap_reg_reader;

  localparam int RD_WAIT = 4;
  localparam int TIMEOUT = 255;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RD_REQ;
  logic [5:0]  RD_ADDR;
  logic        RD_BUSY, RD_VALID, RD_ERR;
  logic [15:0] RD_DATA;
  logic        ICAP_CE, ICAP_WRITE, ICAP_BUSY;
  logic [15:0] ICAP_I, ICAP_O;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] log_q[$];
  logic [15:0] m_val = 16'h0000;
  int          m_n = 0;
  int          rd_cyc = 0;
  logic        prev_ce = 1'b1;
  logic        prev_wr = 1'b1;

  icap_reg_reader #(.RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .RD_BUSY(RD_BUSY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_ERR(RD_ERR),
    .ICAP_CE(ICAP_CE), .ICAP_WRITE(ICAP_WRITE), .ICAP_I(ICAP_I),
    .ICAP_O(ICAP_O), .ICAP_BUSY(ICAP_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] x);
    logic [7:0] hi, lo, hr, lr;
    hi = x[15:8];
    lo = x[7:0];
    hr = {<<{hi}};
    lr = {<<{lo}};
    return {hr, lr};
  endfunction

  // ICAP model: BUSY covers the fixed wait window plus m_n polled cycles
  always @(negedge CLK) begin
    if (ICAP_CE == 1'b0 && ICAP_WRITE == 1'b0) log_q.push_back(swap16(ICAP_I));
    if (ICAP_CE == 1'b0 && ICAP_WRITE == 1'b1) rd_cyc++;
    else rd_cyc = 0;
    ICAP_BUSY = (rd_cyc != 0) && (rd_cyc <= m_n + RD_WAIT - 2);
    ICAP_O    = swap16(m_val);
    if (prev_ce == 1'b0 && ICAP_CE == 1'b0) check("we_stable", 32'(ICAP_WRITE), 32'(prev_wr));
    prev_ce = ICAP_CE;
    prev_wr = ICAP_WRITE;
  end

  task automatic do_read(input logic [5:0] addr, input logic [15:0] val, input int n,
                         input bit pulse_all, output int lat);
    @(negedge CLK);
    log_q.delete();
    m_val   = val;
    m_n     = n;
    RD_ADDR = addr;
    RD_REQ  = 1'b1;
    lat     = 0;
    while (lat < 400) begin
      @(posedge CLK);
      #1;
      lat++;
      if (pulse_all) RD_ADDR = addr ^ 6'h15;
      else RD_REQ = 1'b0;
      if (RD_VALID) break;
    end
    if (lat >= 400) check("valid_timeout", 32'd0, 32'd1);
    check("busy_in_done", 32'(RD_BUSY), 32'd1);
    @(posedge CLK);
    #1;
    RD_REQ = 1'b0;
    check("busy_drop", 32'(RD_BUSY), 32'd0);
    check("valid_pulse", 32'(RD_VALID), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"},    32'(ICAP_CE),    32'd1);
    check({tag, "_wr"},    32'(ICAP_WRITE), 32'd1);
    check({tag, "_i"},     32'(ICAP_I),     32'h0000FFFF);
    check({tag, "_busy"},  32'(RD_BUSY),    32'd0);
    check({tag, "_valid"}, 32'(RD_VALID),   32'd0);
    check({tag, "_data"},  32'(RD_DATA),    32'd0);
    check({tag, "_err"},   32'(RD_ERR),     32'd0);
  endtask

  logic [15:0] t1_words [11] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h2C01,
                                 16'h2000, 16'h2000, 16'h30A1, 16'h000D, 16'h2000, 16'h2000};

  initial begin
    int lat;
    RESET = 1'b1; RD_REQ = 1'b0; RD_ADDR = '0;
    repeat (2) @(negedge CLK);
    check_reset_vals("rst");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // T1: BOOTSTS, no extra BUSY
    do_read(6'h20, 16'h0001, 0, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'd20);
    check("t1_data", 32'(RD_DATA), 32'h0001);
    check("t1_err", 32'(RD_ERR), 32'd0);
    check("t1_nwords", 32'(log_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < log_q.size()) check($sformatf("t1_word%0d", i), 32'(log_q[i]), 32'(t1_words[i]));

    // T2: STAT with 10 busy polls
    do_read(6'h08, 16'h3CEC, 10, 1'b0, lat);
    check("t2_lat", 32'(lat), 32'd30);
    check("t2_data", 32'(RD_DATA), 32'h3CEC);
    if (log_q.size() > 4) check("t2_hdr", 32'(log_q[4]), 32'h2901);

    // T3: BUSY stuck, then a good read clears the error
    do_read(6'h20, 16'h7777, 100000, 1'b0, lat);
    check("t3_lat", 32'(lat), 32'd275);
    check("t3_err", 32'(RD_ERR), 32'd1);
    check("t3_data", 32'(RD_DATA), 32'h0000);
    check("t3_nwords", 32'(log_q.size()), 32'd11);
    if (log_q.size() > 8) begin
      check("t3_dsync_c", 32'(log_q[7]), 32'h30A1);
      check("t3_dsync_v", 32'(log_q[8]), 32'h000D);
    end
    do_read(6'h13, 16'hBEEF, 2, 1'b0, lat);
    check("t3b_lat", 32'(lat), 32'd22);
    check("t3b_err", 32'(RD_ERR), 32'd0);
    check("t3b_data", 32'(RD_DATA), 32'hBEEF);
    if (log_q.size() > 4) check("t3b_hdr", 32'(log_q[4]), 32'h2A61);

    // T4: RD_REQ held every cycle, RD_ADDR disturbed after acceptance
    do_read(6'h14, 16'h1234, 0, 1'b1, lat);
    check("t4_lat", 32'(lat), 32'd20);
    check("t4_data", 32'(RD_DATA), 32'h1234);
    check("t4_nwords", 32'(log_q.size()), 32'd11);
    if (log_q.size() > 4) check("t4_hdr", 32'(log_q[4]), 32'h2A81);
    repeat (3) @(negedge CLK);
    check("t4_idle", 32'(RD_BUSY), 32'd0);
    check("t4_nwords_after", 32'(log_q.size()), 32'd11);

    // T5: reset while polling BUSY
    @(negedge CLK);
    log_q.delete();
    m_val = 16'h5A5A; m_n = 50; RD_ADDR = 6'h20; RD_REQ = 1'b1;
    @(posedge CLK);
    #1 RD_REQ = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    check("t5_pre_ce", 32'(ICAP_CE), 32'd0);
    check("t5_pre_wr", 32'(ICAP_WRITE), 32'd1);
    #1 RESET = 1'b1;
    #1 check_reset_vals("t5");
    @(negedge CLK);
    RESET = 1'b0;
    do_read(6'h17, 16'hA5C3, 1, 1'b0, lat);
    check("t5_lat", 32'(lat), 32'd21);
    check("t5_data", 32'(RD_DATA), 32'hA5C3);
    check("t5_err", 32'(RD_ERR), 32'd0);
    if (log_q.size() > 4) check("t5_hdr", 32'(log_q[4]), 32'h2AE1);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
